mul_shift_add_core: RTL
=======================

Name: mul_shift_add_core

Overview:
Sequencing and accumulation stage of the calculator's unsigned shift-add multiplier.
- Sits directly upstream and downstream of the multiplicand register.
- Upstream: drives that register's ld_x load strobe.
- Downstream: consumes its held value (to_dividend, here port mcand) each iteration.
- Accumulates the partial product in an internal A:Q register pair and presents the final product with a one-cycle done pulse.

Parameters:
N, 4, operand width in bits (multiplicand and multiplier); product is 2N bits; iteration counter is clog2(N)+1 bits.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request a multiplication; sampled only in IDLE
y  input  N  multiplier operand from common y bus; captured on the start-accept edge
mcand  input  N  multiplicand, from multiplicand register output; must be stable while busy
ld_x  output  1  load strobe to multiplicand register; high exactly one cycle per operation
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; product valid from this cycle on
product  output  2N  registered result; holds until next completion

Behaviour:
Reset (async, rst_n=0):
- State goes to IDLE.
- A, Q, count, product all clear to 0.
- ld_x, busy and done are 0.
- Reset asserted mid-operation aborts the operation: no done pulse, product reads 0.

States: IDLE, LOAD, CALC, DONE (2-bit encoded). Outputs are a decode of the registered state only.

IDLE:
- busy=0.
- On an edge with start=1: go to LOAD; A<=0, Q<=y, count<=0.
- start=0: remain in IDLE.

LOAD:
- ld_x=1, busy=1.
- The multiplicand register captures x on the next edge.
- Unconditional transition to CALC.
- mcand is valid from the first CALC cycle.

CALC (N cycles), per edge:
- S = {1'b0,A} + (Q[0] ? mcand : 0), computed at N+1 bits.
- {A,Q} <= {S,Q} >> 1, i.e. A<=S[N:1], Q<={S[0],Q[N-1:1]}.
- count<=count+1.
- On the edge where count==N-1: go to DONE and product<={next A, next Q}.
- No overflow is possible: the maximum product (2^N-1)^2 fits in 2N bits.

DONE:
- done=1, busy=1 for exactly one cycle.
- Unconditional return to IDLE.

start handling:
- start is ignored in LOAD, CALC and DONE; no queuing.
- y changes after acceptance are ignored.
- mcand changes during CALC are used as-is (caller's responsibility).

Latency, with E0 = the edge that accepts start:
- ld_x high during E0-E1.
- CALC during E1-E5.
- product updates at E5; done high during E5-E6.
- IDLE at E6; next start can be accepted at E7.
- Continuous start=1 therefore yields one result every 7 cycles.

product holds its value through IDLE and through subsequent LOAD/CALC until the next DONE.

Test Plan:
- Reset: assert rst_n=0 mid-CALC of 9*6 -> immediately state IDLE, product=0, busy=0, no done pulse; after release an idle bench sees no activity.
- Basic: x=9 loaded via ld_x, y=6, start pulse -> ld_x high exactly 1 cycle after accept, done at E5-E6, product=0x36 (54).
- Extremes: 15*15 -> product=0xE1 (225); 0*13 -> 0x00; 13*0 -> 0x00; 1*15 -> 0x0F.
- start held high for 3 operations with y=3,5,7 and x=4 -> done pulses 7 cycles apart, products 12, 20, 28; ld_x exactly once per operation.
- start pulsed and y changed to 0 during CALC/DONE -> operation unaffected (9*6 still yields 54); no extra done or ld_x.
- Hold check: after completion, product stays 54 through 20 idle cycles and through the CALC phase of the next op, updating only at its DONE.

Source files
------------

// File: rtl/mul_shift_add_core.sv
// Sequencer and A:Q accumulator for an unsigned shift-add multiplier.
// Strobes the external multiplicand register, runs N add/shift steps, then emits the product with a done pulse.
module mul_shift_add_core #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     y,
    input  logic [N-1:0]     mcand,
    output logic             ld_x,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product
);

    localparam int            CW   = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [N-1:0]     a_q;
    logic [N-1:0]     q_q;
    logic [N-1:0]     a_d;
    logic [N-1:0]     q_d;
    logic [N:0]       sum_d;
    logic [CW-1:0]    count_q;
    logic [2*N-1:0]   product_q;

    // One iteration: add the multiplicand when the multiplier LSB is set, then shift {carry,A,Q} right by one.
    always_comb begin
        sum_d = {1'b0, a_q} + (q_q[0] ? {1'b0, mcand} : '0);
        a_d   = sum_d[N:1];
        q_d   = {sum_d[0], q_q[N-1:1]};
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        a_q     <= '0;
                        q_q     <= y;
                        count_q <= '0;
                    end
                end
                LOAD: state_q <= CALC;
                CALC: begin
                    a_q     <= a_d;
                    q_q     <= q_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST) begin
                        state_q   <= DONE;
                        product_q <= {a_d, q_d};
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Control outputs decode only the registered state, so they are glitch-free.
    assign ld_x    = (state_q == LOAD);
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule
